instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
- Upstream neighbour of the instruction-decode FSM controller.
- Owns the program counter and fetches 32-bit instruction words from instruction memory over a req/ack handshake.
- Presents each word, and its 10-bit opcode field, stable to the controller. Holds it until the controller signals completion, then advances the PC sequentially or by a branch offset.
- Detects a HALT opcode and memory-ack timeouts, and stops fetching on either.

Parameters:
- ADDR_W, 16: PC / instruction-memory byte-address width.
- RESET_PC, 0: PC value after reset; must be a multiple of 4.
- HALT_OPCODE, 10'h3FF: opcode value (instr[31:22]) that halts fetch.
- TIMEOUT, 15: maximum cycles to wait for imem_ack before flagging fetch_error; range 1..255.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_req  out  1  fetch request to instruction memory
- imem_addr  out  ADDR_W  byte address of requested word
- imem_ack  in  1  memory has imem_rdata valid this cycle
- imem_rdata  in  32  instruction word from memory
- instruction  out  32  latched instruction word for the controller
- opcode  out  10  instruction[31:22]
- instr_valid  out  1  instruction/opcode are valid and stable
- instr_done  in  1  controller finished the current instruction (1-cycle pulse)
- branch  in  1  take branch; sampled only with instr_done
- branch_offset  in  19  signed word offset (two's complement)
- pc  out  ADDR_W  address of the instruction currently held
- halted  out  1  HALT opcode fetched; sticky until rst
- fetch_error  out  1  ack timeout occurred; sticky until rst

Behaviour:
- All outputs are registered.
- Reset values (applied asynchronously while rst=1):
  - pc=RESET_PC, imem_addr=RESET_PC
  - imem_req=0, instruction=0, opcode=0, instr_valid=0
  - halted=0, fetch_error=0
  - timeout counter=0, state=REQ
- Reset mid-request abandons the transaction; the first request after reset deasserts is to RESET_PC.
- State REQ:
  - imem_req=1 and imem_addr=pc are driven from the first edge after rst deasserts.
  - imem_req stays high until imem_ack is sampled 1.
  - On the edge where imem_ack=1:
    - latch instruction<=imem_rdata and imem_req<=0; reset the counter.
    - If imem_rdata[31:22]==HALT_OPCODE: go HALTED, halted<=1, instr_valid stays 0.
    - Otherwise: go ISSUE, instr_valid<=1.
  - Each edge with imem_ack=0 increments the counter. When the counter reaches TIMEOUT: fetch_error<=1, imem_req<=0, go HALTED.
  - Minimum latency: ack in the first request cycle gives instr_valid high on the next edge, i.e. 2 cycles from request to valid.
- State ISSUE:
  - instruction, opcode and pc are held constant and instr_valid=1.
  - On an edge with instr_done=1:
    - instr_valid<=0, go REQ.
    - If branch=1: pc<=pc+(sign_extend(branch_offset)<<2). Otherwise pc<=pc+4.
    - imem_addr follows the new pc and imem_req<=1 on the same edge, so there are no idle cycles between instructions.
- State HALTED:
  - imem_req=0 and instr_valid=0.
  - All inputs are ignored; the state exits only via rst.
- Arithmetic:
  - PC adds are modulo 2^ADDR_W; wrap-around is silent (e.g. max aligned address +4 gives 0).
  - pc[1:0] and imem_addr[1:0] are always 0.
  - Offset is sign-extended to ADDR_W before the add.
- Ignored-input rules:
  - imem_ack outside REQ is ignored; instruction is not overwritten.
  - instr_done outside ISSUE is ignored.
  - branch without instr_done is ignored.
  - imem_rdata is sampled only on the ack edge.
- Simultaneous events:
  - An ack on the same edge the counter reaches TIMEOUT counts as success; no error is flagged.

Test Plan:
- Reset, then ack every request on its first cycle with words 0x8A000000, 0xCB000000; pulse instr_done 3 cycles after each valid. Required: imem_addr 0,4,8; instr_valid high 1 cycle after ack; opcode 10'b1000101000 then 10'b1100101100.
- Hold ack low 3 cycles before asserting. Required: imem_req and imem_addr stable throughout; no instr_valid until the edge after ack; fetch_error=0.
- At pc=8, branch=1 with offset=-2 on the instr_done edge. Required: next imem_addr=0. With offset=+5: required next imem_addr=28.
- Fetch word 0xFFC00000. Required: halted=1, instr_valid stays 0, imem_req=0 permanently; later ack/instr_done pulses cause no change.
- Never ack (TIMEOUT=15). Required: fetch_error=1 after 15 waiting edges, imem_req drops; ack on the 15th edge instead gives normal ISSUE with fetch_error=0.
- Assert rst mid-REQ and again mid-ISSUE at pc=0x20. Required: outputs return immediately to reset values; the first post-reset request is to address 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Owns the PC, fetches 32-bit words over a req/ack handshake and
//               holds each one stable for the decode controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int               ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter logic [9:0]       HALT_OPCODE = 10'h3FF,
  parameter int               TIMEOUT     = 15
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [31:0]       instruction,
  output logic [9:0]        opcode,
  output logic              instr_valid,
  input  logic              instr_done,
  input  logic              branch,
  input  logic [18:0]       branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic              halted,
  output logic              fetch_error
);

  typedef enum logic [1:0] {
    REQ    = 2'd0,
    ISSUE  = 2'd1,
    HALTED = 2'd2
  } state_t;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

  state_t            state, state_nx;
  logic [7:0]        cnt, cnt_nx, cnt_inc;
  logic [ADDR_W-1:0] pc_nx, addr_nx, off_bytes, pc_target;
  logic              req_nx, valid_nx, halted_nx, error_nx;
  logic [31:0]       instr_nx;
  logic [9:0]        opcode_nx;

  // Word offset sign-extended well past ADDR_W, scaled to bytes, then cut to ADDR_W.
  assign off_bytes = ADDR_W'({{ADDR_W{branch_offset[18]}}, branch_offset, 2'b00});
  assign pc_target = branch ? (pc + off_bytes) : (pc + ADDR_W'(4));
  assign cnt_inc   = cnt + 8'd1;

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    pc_nx     = pc;
    addr_nx   = imem_addr;
    req_nx    = imem_req;
    instr_nx  = instruction;
    opcode_nx = opcode;
    valid_nx  = instr_valid;
    halted_nx = halted;
    error_nx  = fetch_error;
    case (state)
      REQ: begin
        if (!imem_req) begin
          // First cycle out of reset: launch the request, nothing to sample yet.
          req_nx  = 1'b1;
          addr_nx = pc;
        end else if (imem_ack) begin
          instr_nx  = imem_rdata;
          opcode_nx = imem_rdata[31:22];
          req_nx    = 1'b0;
          cnt_nx    = 8'd0;
          if (imem_rdata[31:22] == HALT_OPCODE) begin
            state_nx  = HALTED;
            halted_nx = 1'b1;
          end else begin
            state_nx = ISSUE;
            valid_nx = 1'b1;
          end
        end else begin
          cnt_nx = cnt_inc;
          if (cnt_inc == TIMEOUT_CNT) begin
            error_nx = 1'b1;
            req_nx   = 1'b0;
            state_nx = HALTED;
          end
        end
      end
      ISSUE: begin
        if (instr_done) begin
          valid_nx = 1'b0;
          state_nx = REQ;
          pc_nx    = pc_target;
          addr_nx  = pc_target;
          req_nx   = 1'b1;
        end
      end
      HALTED: begin
        req_nx   = 1'b0;
        valid_nx = 1'b0;
      end
      default: state_nx = REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= REQ;
      cnt         <= 8'd0;
      pc          <= RESET_PC;
      imem_addr   <= RESET_PC;
      imem_req    <= 1'b0;
      instruction <= 32'd0;
      opcode      <= 10'd0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_error <= 1'b0;
    end else begin
      state       <= state_nx;
      cnt         <= cnt_nx;
      pc          <= pc_nx;
      imem_addr   <= addr_nx;
      imem_req    <= req_nx;
      instruction <= instr_nx;
      opcode      <= opcode_nx;
      instr_valid <= valid_nx;
      halted      <= halted_nx;
      fetch_error <= error_nx;
    end
  end

endmodule

`default_nettype wire
